tick_timer_sched: RTL
=====================

Name: tick_timer_sched

Overview:
Shared-timebase timeout scheduler. One prescaler derives a tick from CLOCK. NCH requesters arm independent countdown timers over a valid/ready handshake. A single sequenced decrement datapath services the timers round-robin, once per tick. Sits beside the second-counter/LED logic so that UART, LED and housekeeping blocks share one timebase instead of each owning a wide counter.

Parameters:
CLOCK_Fre, 4000000, CLOCK frequency in Hz
TICK_HZ, 1000, tick rate; PRESCALE = CLOCK_Fre/TICK_HZ; elaboration error if PRESCALE < NCH+2
NCH, 4, number of timer channels (2..8)
CW, 16, countdown width in ticks

Ports:
CLOCK  in  1  clock
rst  in  1  synchronous reset, active-high
arm_valid  in  NCH  per-channel arm request
arm_ticks  in  NCH*CW  per-channel timeout; channel i at [i*CW +: CW]
arm_ready  out  NCH  per-channel grant; at most one bit set
cancel  in  NCH  per-channel cancel, level-sampled each cycle
expired  out  NCH  one-cycle pulse per expiry
active  out  NCH  channel currently counting
tick  out  1  one-cycle prescaler strobe
overrun  out  1  sticky; tick arrived while previous tick still pending

Behaviour:
- Reset: prescaler=0, all count=0, active=0, expired=0, arm_ready=0, tick=0, overrun=0, tick_pending=0, RR pointer=0, FSM=IDLE. Reset mid-scan aborts the scan. Pending handshakes are dropped.
- Prescaler counts 0..PRESCALE-1. tick=1 for the cycle in which it equals PRESCALE-1, then it wraps to 0. A tick sets tick_pending. If tick_pending is already 1, overrun is set and stays set until rst.
- FSM IDLE:
  - If tick_pending=1: arm_ready=0; next state SCAN, idx=0, tick_pending cleared.
  - Otherwise arm_ready is combinational: a one-hot grant to the first requesting channel at or after the RR pointer.
  - Handshake (arm_valid[i]&arm_ready[i]):
    - count[i]<=arm_ticks[i], active[i]<=1, RR pointer<=i+1 mod NCH.
    - Re-arming an active channel restarts it.
    - arm_ticks=0: active stays 0, expired[i] pulses the next cycle.
- FSM SCAN: one channel per cycle, idx 0..NCH-1.
  - Channel active and count=1: expired[idx] pulses the next cycle, active<=0.
  - Channel active and count>1: count<=count-1.
  - Inactive channels are untouched.
  - After idx=NCH-1: IDLE. A scan always takes exactly NCH cycles.
  - No arm is granted during SCAN; arm_valid must be held (valid stays high until ready).
- Expiry latency: an arm of N≥1 ticks expires during the Nth scan started after the handshake. Wall time is between (N-1)*PRESCALE and N*PRESCALE cycles plus NCH+1.
- Cancel:
  - cancel[i]=1 forces active[i]<=0 and suppresses expired[i] for that cycle.
  - Cancel beats both a same-cycle scan expiry and a same-cycle arm grant; arm_ready[i] is masked while cancel[i]=1.
- Counts are unsigned CW-bit and never wrap below 1 because of the expiry check.

Optional Feature:
TICK_TIMER_SCHED_PERIODIC_EN:
- Defined: adds input periodic (NCH) and a per-channel reload register. On handshake, reload[i]<=arm_ticks[i] and periodic[i] is latched. On expiry of a periodic channel, count<=reload and active stays 1; expired still pulses. A periodic arm with 0 ticks is treated as 1.
- Undefined: no periodic port and no reload registers; every expiry is one-shot.

Test Plan:
- Sim parameters for all scenarios: CLOCK_Fre=64, TICK_HZ=8 (PRESCALE=8), NCH=4.
- Reset/tick: release rst → tick pulses at cycles 7, 15, 23; all outputs 0 until then; overrun stays 0.
- Single arm: ch2 arm_ticks=3 → arm_ready[2] high in the same cycle, active[2]=1; expired[2] pulses exactly once on the 3rd scan (channel slot 2), then active[2]=0.
- Contention: ch0, ch1, ch3 assert arm_valid together → grants in order 0, 1, 3 on consecutive IDLE cycles; with ch0 re-requesting, the next grant order is 1, 3, 0. No two arm_ready bits are ever high together.
- Cancel race: ch1 arm_ticks=1, cancel[1] asserted in its scan slot → no expired[1] pulse, active[1]=0. Arm with arm_ticks=0 → expired pulse 1 cycle after handshake.
- Mid-operation reset: rst asserted during SCAN idx=2 with 3 channels active → next cycle all active=0, no expired pulses, prescaler restarts from 0.
- Periodic (macro defined): ch0 periodic, 2 ticks → expired[0] pulses every 2nd scan for 5 periods; cancel stops it. With PRESCALE forced to NCH+1 via TICK_HZ override → elaboration error.

Source files
------------

// File: rtl/tick_timer_sched.sv
// Shared-timebase timeout scheduler: one prescaler tick drives a round-robin decrement scan over NCH timers.
// Optional periodic reload is enabled by defining TICK_TIMER_SCHED_PERIODIC_EN.
//
// state | meaning
// IDLE  | arms granted round-robin; leaves for SCAN when a tick is pending
// SCAN  | one channel per cycle, idx 0..NCH-1, decrement / expire
module tick_timer_sched #(
    parameter int CLOCK_Fre = 4000000,
    parameter int TICK_HZ   = 1000,
    parameter int NCH       = 4,
    parameter int CW        = 16
) (
    input  logic              CLOCK,
    input  logic              rst,
    input  logic [NCH-1:0]    arm_valid,
    input  logic [NCH*CW-1:0] arm_ticks,
`ifdef TICK_TIMER_SCHED_PERIODIC_EN
    input  logic [NCH-1:0]    periodic,
`endif
    output logic [NCH-1:0]    arm_ready,
    input  logic [NCH-1:0]    cancel,
    output logic [NCH-1:0]    expired,
    output logic [NCH-1:0]    active,
    output logic              tick,
    output logic              overrun
);

    localparam int PRESCALE = CLOCK_Fre / TICK_HZ;
    localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW       = $clog2(NCH);

    // The scan must finish before the next tick can land, otherwise ticks are lost.
    generate
        if (PRESCALE < NCH + 2) begin : g_bad_prescale
            $error("tick_timer_sched: PRESCALE must be at least NCH+2");
        end
        if (NCH < 2 || NCH > 8) begin : g_bad_nch
            $error("tick_timer_sched: NCH must be in 2..8");
        end
    endgenerate

    typedef enum logic [0:0] {ST_IDLE, ST_SCAN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic            r_tick_pending;
    logic            r_overrun;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   r_rr;
    logic [CW-1:0]   r_count [NCH];
    logic [NCH-1:0]  r_active;
    logic [NCH-1:0]  r_expired;
`ifdef TICK_TIMER_SCHED_PERIODIC_EN
    logic [CW-1:0]   r_reload [NCH];
    logic [NCH-1:0]  r_periodic;
`endif

    logic            w_tick;
    logic            w_scan;
    logic            w_start_scan;
    logic [NCH-1:0]  w_req;
    logic [NCH-1:0]  w_grant;
    logic [NCH-1:0]  w_hs;
    logic [IW-1:0]   w_gnt_idx;

    assign w_tick  = (r_presc == PW'(PRESCALE - 1));
    assign w_scan  = (r_state == ST_SCAN);
    assign w_req   = arm_valid & ~cancel;
    assign w_hs    = arm_valid & w_grant;

    assign arm_ready = w_grant;
    assign expired   = r_expired;
    assign active    = r_active;
    assign tick      = w_tick;
    assign overrun   = r_overrun;

    always_comb begin
        int   j;
        logic w_found;
        w_state_nxt  = r_state;
        w_start_scan = 1'b0;
        w_grant      = '0;
        w_gnt_idx    = '0;
        w_found      = 1'b0;
        j            = 0;
        case (r_state)
            ST_IDLE: begin
                if (r_tick_pending) begin
                    w_state_nxt  = ST_SCAN;
                    w_start_scan = 1'b1;
                end else if (!rst) begin
                    for (int k = 0; k < NCH; k++) begin
                        j = (int'(r_rr) + k) % NCH;
                        if (!w_found && w_req[j]) begin
                            w_found    = 1'b1;
                            w_grant[j] = 1'b1;
                            w_gnt_idx  = IW'(j);
                        end
                    end
                end
            end
            ST_SCAN: begin
                if (r_idx == IW'(NCH - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_scan) begin
                r_idx <= '0;
            end else if (w_scan) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_presc        <= '0;
            r_tick_pending <= 1'b0;
            r_overrun      <= 1'b0;
            r_rr           <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_tick_pending <= 1'b1;
                if (r_tick_pending) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_start_scan) begin
                r_tick_pending <= 1'b0;
            end
            if (|w_hs) begin
                r_rr <= (w_gnt_idx == IW'(NCH - 1)) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            r_active  <= '0;
            r_expired <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_count[i] <= '0;
`ifdef TICK_TIMER_SCHED_PERIODIC_EN
                r_reload[i] <= '0;
`endif
            end
`ifdef TICK_TIMER_SCHED_PERIODIC_EN
            r_periodic <= '0;
`endif
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_expired[i] <= 1'b0;
                if (w_hs[i]) begin
`ifdef TICK_TIMER_SCHED_PERIODIC_EN
                    r_periodic[i] <= periodic[i];
                    if (periodic[i] && arm_ticks[i*CW +: CW] == '0) begin
                        r_count[i]  <= CW'(1);
                        r_reload[i] <= CW'(1);
                        r_active[i] <= 1'b1;
                    end else begin
                        r_count[i]   <= arm_ticks[i*CW +: CW];
                        r_reload[i]  <= arm_ticks[i*CW +: CW];
                        r_active[i]  <= (arm_ticks[i*CW +: CW] != '0);
                        r_expired[i] <= (arm_ticks[i*CW +: CW] == '0);
                    end
`else
                    r_count[i]   <= arm_ticks[i*CW +: CW];
                    r_active[i]  <= (arm_ticks[i*CW +: CW] != '0);
                    r_expired[i] <= (arm_ticks[i*CW +: CW] == '0);
`endif
                end else if (w_scan && r_idx == IW'(i) && r_active[i]) begin
                    if (r_count[i] == CW'(1)) begin
                        r_expired[i] <= 1'b1;
`ifdef TICK_TIMER_SCHED_PERIODIC_EN
                        if (r_periodic[i]) begin
                            r_count[i] <= r_reload[i];
                        end else begin
                            r_active[i] <= 1'b0;
                        end
`else
                        r_active[i] <= 1'b0;
`endif
                    end else begin
                        r_count[i] <= r_count[i] - 1'b1;
                    end
                end
                // Cancel overrides any expiry or arm resolved in the same cycle.
                if (cancel[i]) begin
                    r_active[i]  <= 1'b0;
                    r_expired[i] <= 1'b0;
                end
            end
        end
    end

endmodule
